// File: rtl/cv32e40p_tmr_pkg.sv
`default_nettype none
// ============================================================================
// Module : cv32e40p_tmr_pkg
// Brief  : Shared types and default widths for the TMR result checker.
// Rev    : 1.0
// ============================================================================
package cv32e40p_tmr_pkg;

  localparam int DEFAULT_DIV_W  = 33;
  localparam int DEFAULT_MULT_W = 35;
  localparam int NUM_REPLICAS   = 3;

  typedef enum logic [1:0] {
    HEALTHY = 2'd0,
    SUSPECT = 2'd1,
    FAILED  = 2'd2
  } replica_state_e;

endpackage
`default_nettype wire

// File: rtl/cv32e40p_tmr_replica_monitor.sv
`default_nettype none
// ============================================================================
// Module : cv32e40p_tmr_replica_monitor
// Brief  : Health tracker for one replica: run-length FSM, saturating error
//          counter and sticky fault flag.
// Rev    : 1.0
// ============================================================================
module cv32e40p_tmr_replica_monitor
  import cv32e40p_tmr_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int PERSIST_TH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_mismatch,
  input  logic             i_clear,
  output logic             o_sticky,
  output logic             o_failed,
  output logic             o_failed_nxt,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int               RUN_W   = $clog2(PERSIST_TH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_TH  = RUN_W'(PERSIST_TH);

  replica_state_e   r_state, w_state_nxt;
  logic [RUN_W-1:0] r_run, w_run_nxt, w_run_inc;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_sticky, w_sticky_nxt;

  assign w_run_inc = r_run + RUN_W'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_run_nxt    = r_run;
    w_cnt_nxt    = r_cnt;
    w_sticky_nxt = r_sticky;
    if (i_clear) begin
      w_state_nxt  = HEALTHY;
      w_run_nxt    = '0;
      w_cnt_nxt    = '0;
      w_sticky_nxt = 1'b0;
    end else if (i_mismatch) begin
      w_sticky_nxt = 1'b1;
      if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + CNT_W'(1);
      case (r_state)
        HEALTHY: begin
          w_state_nxt = SUSPECT;
          w_run_nxt   = RUN_W'(1);
        end
        SUSPECT: begin
          w_run_nxt = w_run_inc;
          if (w_run_inc == RUN_TH) w_state_nxt = FAILED;
        end
        default: w_state_nxt = FAILED;
      endcase
    end else if (r_state == SUSPECT) begin
      w_state_nxt = HEALTHY;
      w_run_nxt   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= HEALTHY;
      r_run    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_run    <= w_run_nxt;
      r_cnt    <= w_cnt_nxt;
      r_sticky <= w_sticky_nxt;
    end
  end

  assign o_sticky     = r_sticky;
  assign o_failed     = (r_state == FAILED);
  assign o_failed_nxt = (w_state_nxt == FAILED);
  assign o_err_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: rtl/cv32e40p_tmr_checker.sv
`default_nettype none
// ============================================================================
// Module : cv32e40p_tmr_checker
// Brief  : Majority-votes triplicated div/mult results, blames disagreeing
//          replicas and aggregates fault status into a single alarm.
// Rev    : 1.0
// ============================================================================
module cv32e40p_tmr_checker
  import cv32e40p_tmr_pkg::*;
#(
  parameter int DIV_W      = DEFAULT_DIV_W,
  parameter int MULT_W     = DEFAULT_MULT_W,
  parameter int CNT_W      = 16,
  parameter int PERSIST_TH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [DIV_W-1:0]          div_in_0,
  input  logic [DIV_W-1:0]          div_in_1,
  input  logic [DIV_W-1:0]          div_in_2,
  input  logic [MULT_W-1:0]         mult_in_0,
  input  logic [MULT_W-1:0]         mult_in_1,
  input  logic [MULT_W-1:0]         mult_in_2,
  input  logic                      cs_error_i,
  input  logic                      clear_i,
  output logic [DIV_W-1:0]          div_voted_o,
  output logic [MULT_W-1:0]         mult_voted_o,
  output logic [2:0]                mismatch_o,
  output logic [2:0]                fault_sticky_o,
  output logic [2:0]                failed_o,
  output logic [3*CNT_W-1:0]        err_cnt_o,
  output logic                      uncorr_o,
  output logic                      cs_error_sticky_o,
  output logic                      alarm_o
);

  function automatic logic [DIV_W-1:0] vote_div(input logic [DIV_W-1:0] a, b, c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [MULT_W-1:0] vote_mult(input logic [MULT_W-1:0] a, b, c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic [DIV_W-1:0]  w_div_in  [NUM_REPLICAS];
  logic [MULT_W-1:0] w_mult_in [NUM_REPLICAS];
  logic [DIV_W-1:0]  w_div_vote;
  logic [MULT_W-1:0] w_mult_vote;
  logic [2:0]        w_mismatch;
  logic [2:0]        w_failed_nxt;
  logic              w_uncorr, w_uncorr_nxt, w_cs_nxt;

  assign w_div_in[0]  = div_in_0;
  assign w_div_in[1]  = div_in_1;
  assign w_div_in[2]  = div_in_2;
  assign w_mult_in[0] = mult_in_0;
  assign w_mult_in[1] = mult_in_1;
  assign w_mult_in[2] = mult_in_2;

  assign w_div_vote  = vote_div(div_in_0, div_in_1, div_in_2);
  assign w_mult_vote = vote_mult(mult_in_0, mult_in_1, mult_in_2);

  // Three-way disagreement cannot be attributed to a single replica.
  assign w_uncorr = ((div_in_0 != div_in_1) && (div_in_1 != div_in_2) && (div_in_0 != div_in_2)) ||
                    ((mult_in_0 != mult_in_1) && (mult_in_1 != mult_in_2) && (mult_in_0 != mult_in_2));

  generate
    for (genvar r = 0; r < NUM_REPLICAS; r++) begin : g_rep
      assign w_mismatch[r] = (w_div_in[r] != w_div_vote) || (w_mult_in[r] != w_mult_vote);

      cv32e40p_tmr_replica_monitor #(
        .CNT_W      (CNT_W),
        .PERSIST_TH (PERSIST_TH)
      ) u_mon (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .i_mismatch   (w_mismatch[r]),
        .i_clear      (clear_i),
        .o_sticky     (fault_sticky_o[r]),
        .o_failed     (failed_o[r]),
        .o_failed_nxt (w_failed_nxt[r]),
        .o_err_cnt    (err_cnt_o[r*CNT_W +: CNT_W])
      );
    end
  endgenerate

  assign w_uncorr_nxt = clear_i ? 1'b0 : (uncorr_o | w_uncorr);
  assign w_cs_nxt     = clear_i ? 1'b0 : (cs_error_sticky_o | cs_error_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_voted_o       <= '0;
      mult_voted_o      <= '0;
      mismatch_o        <= '0;
      uncorr_o          <= 1'b0;
      cs_error_sticky_o <= 1'b0;
      alarm_o           <= 1'b0;
    end else begin
      div_voted_o       <= w_div_vote;
      mult_voted_o      <= w_mult_vote;
      mismatch_o        <= w_mismatch;
      uncorr_o          <= w_uncorr_nxt;
      cs_error_sticky_o <= w_cs_nxt;
      alarm_o           <= w_uncorr_nxt | w_cs_nxt | (|w_failed_nxt);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cv32e40p_tmr_checker.sv
`default_nettype none
// ============================================================================
// Module : tb_cv32e40p_tmr_checker
// Brief  : Directed plus random stimulus against a behavioural TMR model.
// Rev    : 1.0
// ============================================================================
module tb_cv32e40p_tmr_checker;

  localparam int DW = 33;
  localparam int MW = 35;
  localparam int TH = 4;
  localparam logic [DW-1:0] DBASE = 33'h1_2345_6789;
  localparam logic [MW-1:0] MBASE = 35'h0_0000_00AB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] d0, d1, d2;
  logic [MW-1:0] m0, m1, m2;
  logic          cs, clr;

  logic [DW-1:0] dv, dv4;
  logic [MW-1:0] mv, mv4;
  logic [2:0]    mm, mm4, st, st4, fl, fl4;
  logic [47:0]   ec;
  logic [11:0]   ec4;
  logic          unc, unc4, css, css4, alm, alm4;

  cv32e40p_tmr_checker #(.CNT_W(16), .PERSIST_TH(TH)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .div_in_0(d0), .div_in_1(d1), .div_in_2(d2),
    .mult_in_0(m0), .mult_in_1(m1), .mult_in_2(m2),
    .cs_error_i(cs), .clear_i(clr),
    .div_voted_o(dv), .mult_voted_o(mv), .mismatch_o(mm),
    .fault_sticky_o(st), .failed_o(fl), .err_cnt_o(ec),
    .uncorr_o(unc), .cs_error_sticky_o(css), .alarm_o(alm)
  );

  cv32e40p_tmr_checker #(.CNT_W(4), .PERSIST_TH(TH)) dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .div_in_0(d0), .div_in_1(d1), .div_in_2(d2),
    .mult_in_0(m0), .mult_in_1(m1), .mult_in_2(m2),
    .cs_error_i(cs), .clear_i(clr),
    .div_voted_o(dv4), .mult_voted_o(mv4), .mismatch_o(mm4),
    .fault_sticky_o(st4), .failed_o(fl4), .err_cnt_o(ec4),
    .uncorr_o(unc4), .cs_error_sticky_o(css4), .alarm_o(alm4)
  );

  // Reference state
  logic [DW-1:0] e_dv;
  logic [MW-1:0] e_mv;
  logic [2:0]    e_mm, e_st, e_fl;
  int            e_cnt [3];
  int            e_run [3];
  logic          e_unc, e_cs, e_alm;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [MW-1:0] majority(input logic [MW-1:0] a, b, c);
    logic [MW-1:0] v;
    for (int i = 0; i < MW; i++) begin
      int ones;
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      v[i] = (ones >= 2);
    end
    return v;
  endfunction

  function automatic logic [15:0] sat(input int v, input int mx);
    return (v > mx) ? 16'(mx) : 16'(v);
  endfunction

  function automatic logic all_differ(input logic [MW-1:0] a, b, c);
    return (a != b) && (b != c) && (a != c);
  endfunction

  task automatic model_reset();
    e_dv = '0; e_mv = '0; e_mm = '0; e_st = '0; e_fl = '0;
    e_unc = 1'b0; e_cs = 1'b0; e_alm = 1'b0;
    for (int r = 0; r < 3; r++) begin
      e_cnt[r] = 0;
      e_run[r] = 0;
    end
  endtask

  task automatic model_step();
    logic [MW-1:0] dr [3];
    logic [MW-1:0] mr [3];
    logic [MW-1:0] vd;
    logic [MW-1:0] vm;
    logic          u;
    dr[0] = MW'(d0); dr[1] = MW'(d1); dr[2] = MW'(d2);
    mr[0] = m0;      mr[1] = m1;      mr[2] = m2;
    vd = majority(dr[0], dr[1], dr[2]);
    vm = majority(mr[0], mr[1], mr[2]);
    u  = all_differ(dr[0], dr[1], dr[2]) || all_differ(mr[0], mr[1], mr[2]);
    e_dv = vd[DW-1:0];
    e_mv = vm;
    for (int r = 0; r < 3; r++) e_mm[r] = (dr[r] != vd) || (mr[r] != vm);
    if (clr) begin
      e_st = '0; e_fl = '0; e_unc = 1'b0; e_cs = 1'b0;
      for (int r = 0; r < 3; r++) begin
        e_cnt[r] = 0;
        e_run[r] = 0;
      end
    end else begin
      for (int r = 0; r < 3; r++) begin
        if (e_mm[r]) begin
          e_cnt[r]++;
          e_run[r]++;
          e_st[r] = 1'b1;
          if (e_run[r] >= TH) e_fl[r] = 1'b1;
        end else begin
          e_run[r] = 0;
        end
      end
      e_unc = e_unc | u;
      e_cs  = e_cs | cs;
    end
    e_alm = e_unc | e_cs | (|e_fl);
  endtask

  task automatic check_all();
    logic [47:0] x16;
    logic [11:0] x4;
    for (int r = 0; r < 3; r++) begin
      x16[r*16 +: 16] = sat(e_cnt[r], 65535);
      x4[r*4 +: 4]    = 4'(sat(e_cnt[r], 15));
    end
    check_val("div_voted",  64'(dv),  64'(e_dv));
    check_val("mult_voted", 64'(mv),  64'(e_mv));
    check_val("mismatch",   64'(mm),  64'(e_mm));
    check_val("sticky",     64'(st),  64'(e_st));
    check_val("failed",     64'(fl),  64'(e_fl));
    check_val("err_cnt",    64'(ec),  64'(x16));
    check_val("uncorr",     64'(unc), 64'(e_unc));
    check_val("cs_sticky",  64'(css), 64'(e_cs));
    check_val("alarm",      64'(alm), 64'(e_alm));
    check_val("w4_err_cnt", 64'(ec4), 64'(x4));
    check_val("w4_status",  64'({dv4, mv4, mm4, st4, fl4, unc4, css4, alm4}),
                            64'({e_dv, e_mv, e_mm, e_st, e_fl, e_unc, e_cs, e_alm}));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic set_all(input logic [DW-1:0] dvv, input logic [MW-1:0] mvv);
    d0 = dvv; d1 = dvv; d2 = dvv;
    m0 = mvv; m1 = mvv; m2 = mvv;
  endtask

  logic [DW-1:0] rd;
  logic [MW-1:0] rm;
  int            stuck_rep, stuck_len, sel;

  initial begin
    set_all('0, '0);
    cs = 1'b0; clr = 1'b0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // All replicas agree
    set_all(DBASE, MBASE);
    tick(); tick();

    // Single-cycle bit flip on div replica 1
    d1 = DBASE ^ 33'h1;
    tick();
    d1 = DBASE;
    tick(); tick();

    // Persistent mult replica 2 fault reaches FAILED
    m2 = ~MBASE;
    repeat (TH) tick();
    m2 = MBASE;
    tick();

    // Clear wins over a concurrent mismatch
    clr = 1'b1; m0 = MBASE ^ 35'h5;
    tick();
    clr = 1'b0; m0 = MBASE;
    tick();

    // One short of the threshold, then a match
    m2 = MBASE ^ 35'h4_0000_0000;
    repeat (TH - 1) tick();
    m2 = MBASE;
    tick(); tick();

    // Three-way disagreement
    d0 = 33'd1; d1 = 33'd2; d2 = 33'd4;
    tick();
    set_all(DBASE, MBASE);
    tick();
    clr = 1'b1; tick(); clr = 1'b0;

    // Long constant fault drives narrow counter into saturation
    d0 = DBASE ^ 33'h10;
    repeat (20) tick();
    d0 = DBASE;
    tick();

    // cs_error pulse holds until clear
    cs = 1'b1; tick(); cs = 1'b0;
    repeat (3) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    tick();

    // Random traffic
    stuck_rep = 0; stuck_len = 0;
    for (int n = 0; n < 400; n++) begin
      rd = {$urandom, $urandom};
      rm = {$urandom, $urandom};
      set_all(rd, rm);
      sel = $urandom_range(0, 15);
      if (stuck_len == 0 && sel == 0) begin
        stuck_rep = $urandom_range(0, 2);
        stuck_len = $urandom_range(2, 8);
      end
      if (stuck_len > 0) begin
        stuck_len--;
        case (stuck_rep)
          0: m0 = rm ^ 35'h1;
          1: m1 = rm ^ 35'h1;
          default: m2 = rm ^ 35'h1;
        endcase
      end else if (sel >= 10 && sel <= 13) begin
        rd = DW'({$urandom, $urandom} | 64'h1);
        case ($urandom_range(0, 2))
          0: d0 = d0 ^ rd;
          1: d1 = d1 ^ rd;
          default: d2 = d2 ^ rd;
        endcase
      end else if (sel == 14) begin
        m1 = rm ^ 35'h1;
        m2 = rm ^ 35'h2;
      end
      cs  = ($urandom_range(0, 29) == 0);
      clr = ($urandom_range(0, 39) == 0);
      tick();
    end
    cs = 1'b0; clr = 1'b0;

    // Build up some state, then reset asynchronously mid-cycle
    set_all(DBASE, MBASE);
    d2 = ~DBASE; cs = 1'b1;
    repeat (TH) tick();
    cs = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    set_all(DBASE, MBASE);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
